// File: rtl/if_pkg.sv
// Shared constants for the instruction-fetch receive queue.
package if_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int          FQ_DEPTH  = 4;
  localparam int          FQ_DATA_W = 32;
endpackage

// File: rtl/fetch_queue_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one async read port, no reset.
module fetch_queue_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/if_fetch_queue.sv
// Fetch-to-decode FIFO: show-ahead head, freeze when full, flush on taken branch.
module if_fetch_queue
  import if_pkg::*;
#(
  parameter int DEPTH  = FQ_DEPTH,
  parameter int DATA_W = FQ_DATA_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] if_pc_i,
  input  logic [DATA_W-1:0] if_instr_i,
  input  logic              branch_taken_i,
  input  logic              id_stall_i,
  output logic              freeze_o,
  output logic              id_valid_o,
  output logic [DATA_W-1:0] id_pc_o,
  output logic [DATA_W-1:0] id_instr_o,
  output logic [CNT_W-1:0]  count_o
);
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                push, pop;
  logic [2*DATA_W-1:0] rdata;

  // Full/empty come only from registered count, keeping freeze free of input paths.
  assign freeze_o   = (count_q == CNT_W'(DEPTH));
  assign id_valid_o = (count_q != '0);
  assign push       = !freeze_o && !branch_taken_i && !rst;
  assign pop        = id_valid_o && !id_stall_i && !branch_taken_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (branch_taken_i) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fetch_queue_mem #(.DEPTH(DEPTH), .WIDTH(2*DATA_W)) u_mem (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i ({if_pc_i, if_instr_i}),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  assign id_pc_o    = id_valid_o ? rdata[2*DATA_W-1:DATA_W] : '0;
  assign id_instr_o = id_valid_o ? rdata[DATA_W-1:0]        : DATA_W'(NOP_INSTR);
  assign count_o    = count_q;
endmodule
